// File: rtl/dispatch_stage_pkg.sv
// Shared opcode encoding for the dispatch stage and the load/store range check.
package dispatch_stage_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_LUI   = 6'd0;
  localparam logic [OPC_W-1:0] OP_AUIPC = 6'd1;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'd2;
  localparam logic [OPC_W-1:0] OP_JALR  = 6'd3;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OPC_W-1:0] OP_BLT   = 6'd6;
  localparam logic [OPC_W-1:0] OP_BGE   = 6'd7;
  localparam logic [OPC_W-1:0] OP_BLTU  = 6'd8;
  localparam logic [OPC_W-1:0] OP_BGEU  = 6'd9;
  // Loads and stores must stay contiguous: the LSB routing is a range check.
  localparam logic [OPC_W-1:0] OP_LB    = 6'd10;
  localparam logic [OPC_W-1:0] OP_LH    = 6'd11;
  localparam logic [OPC_W-1:0] OP_LW    = 6'd12;
  localparam logic [OPC_W-1:0] OP_LBU   = 6'd13;
  localparam logic [OPC_W-1:0] OP_LHU   = 6'd14;
  localparam logic [OPC_W-1:0] OP_SB    = 6'd15;
  localparam logic [OPC_W-1:0] OP_SH    = 6'd16;
  localparam logic [OPC_W-1:0] OP_SW    = 6'd17;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'd18;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'd19;
  localparam logic [OPC_W-1:0] OP_SLTIU = 6'd20;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'd21;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'd22;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'd23;
  localparam logic [OPC_W-1:0] OP_SLLI  = 6'd24;
  localparam logic [OPC_W-1:0] OP_SRLI  = 6'd25;
  localparam logic [OPC_W-1:0] OP_SRAI  = 6'd26;
  localparam logic [OPC_W-1:0] OP_ADD   = 6'd27;
  localparam logic [OPC_W-1:0] OP_SUB   = 6'd28;
  localparam logic [OPC_W-1:0] OP_SLL   = 6'd29;
  localparam logic [OPC_W-1:0] OP_SLT   = 6'd30;
  localparam logic [OPC_W-1:0] OP_SLTU  = 6'd31;
  localparam logic [OPC_W-1:0] OP_XOR   = 6'd32;
  localparam logic [OPC_W-1:0] OP_SRL   = 6'd33;
  localparam logic [OPC_W-1:0] OP_SRA   = 6'd34;
  localparam logic [OPC_W-1:0] OP_OR    = 6'd35;
  localparam logic [OPC_W-1:0] OP_AND   = 6'd36;

  function automatic logic is_ls(input logic [OPC_W-1:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

endpackage

// File: rtl/dispatch_stage_operand_fwd.sv
// Resolves one operand from {busy tag, value} against the CDB; lowest channel wins.
module operand_fwd #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic [ROB_W:0]         tag,
  input  logic [XLEN-1:0]        val,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_tag,
  input  logic [CDB_N*XLEN-1:0]  cdb_val,
  output logic [XLEN-1:0]        v,
  output logic [ROB_W-1:0]       q,
  output logic                   o
);

  always_comb begin
    v = '0;
    q = '0;
    o = 1'b0;
    if (!tag[ROB_W]) begin
      v = val;
      o = 1'b1;
    end else begin
      q = tag[ROB_W-1:0];
      // Descending scan so the lowest matching channel is the last writer.
      for (int i = CDB_N - 1; i >= 0; i--) begin
        if (cdb_valid[i] && (cdb_tag[i*ROB_W +: ROB_W] == tag[ROB_W-1:0])) begin
          v = cdb_val[i*XLEN +: XLEN];
          q = '0;
          o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// One-entry rename/dispatch register between decode and the RS/LSB.
// DISPATCH_BYPASS_EN: lets a capture from EMPTY dispatch in the same cycle.
module dispatch_stage
  import dispatch_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [5:0]             in_opcode,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [XLEN-1:0]        in_imm,
  input  logic                   in_is_br,
  output logic [4:0]             rf_rs1,
  output logic [4:0]             rf_rs2,
  input  logic [XLEN-1:0]        rf_val1,
  input  logic [XLEN-1:0]        rf_val2,
  input  logic [ROB_W:0]         rf_tag1,
  input  logic [ROB_W:0]         rf_tag2,
  output logic                   rf_issue_en,
  output logic [4:0]             rf_issue_rd,
  output logic [ROB_W-1:0]       rf_issue_tag,
  input  logic [ROB_W-1:0]       rob_free_tag,
  input  logic                   rob_full,
  output logic                   rob_alloc_en,
  input  logic                   flush,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_tag,
  input  logic [CDB_N*XLEN-1:0]  cdb_val,
  input  logic                   rs_full,
  input  logic                   lsb_full,
  output logic                   dis_rs_en,
  output logic                   dis_lsb_en,
  output logic [5:0]             dis_opcode,
  output logic [ROB_W-1:0]       dis_rob_id,
  output logic [XLEN-1:0]        dis_pc,
  output logic [XLEN-1:0]        dis_imm,
  output logic                   dis_is_br,
  output logic [XLEN-1:0]        dis_vi,
  output logic [XLEN-1:0]        dis_vj,
  output logic [ROB_W-1:0]       dis_qi,
  output logic [ROB_W-1:0]       dis_qj,
  output logic                   dis_oi,
  output logic                   dis_oj
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d;
  logic             br_q, br_d;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic [XLEN-1:0]  vi_q, vi_d, vj_q, vj_d;
  logic [ROB_W-1:0] qi_q, qi_d, qj_q, qj_d;
  logic             oi_q, oi_d, oj_q, oj_d;

  logic [XLEN-1:0]  cvi, cvj, hvi, hvj;
  logic [ROB_W-1:0] cqi, cqj, hqi, hqj;
  logic             coi, coj, hoi, hoj;
  logic             go, hold_dis, capture, byp;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  // Capture-time resolution from the (pre-rename) RF lookup.
  operand_fwd #(.XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N)) u_cap_i (
    .tag(rf_tag1), .val(rf_val1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .v(cvi), .q(cqi), .o(coi));
  operand_fwd #(.XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N)) u_cap_j (
    .tag(rf_tag2), .val(rf_val2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .v(cvj), .q(cqj), .o(coj));

  // Held operands re-resolved every cycle; also the dispatch-time forwarding path.
  operand_fwd #(.XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N)) u_hold_i (
    .tag({~oi_q, qi_q}), .val(vi_q), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .v(hvi), .q(hqi), .o(hoi));
  operand_fwd #(.XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N)) u_hold_j (
    .tag({~oj_q, qj_q}), .val(vj_q), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .v(hvj), .q(hqj), .o(hoj));

  assign go       = rdy && !flush && !rst;
  assign hold_dis = go && (state_q == ST_HOLD) && !(is_ls(opc_q) ? lsb_full : rs_full);
  assign in_ready = go && !rob_full && ((state_q == ST_EMPTY) || hold_dis);
  assign capture  = in_valid && in_ready;

`ifdef DISPATCH_BYPASS_EN
  assign byp = capture && (state_q == ST_EMPTY) && !(is_ls(in_opcode) ? lsb_full : rs_full);
`else
  assign byp = 1'b0;
`endif

  assign rob_alloc_en = capture;
  assign rf_issue_en  = capture && (in_rd != 5'd0);
  assign rf_issue_rd  = capture ? in_rd : 5'd0;
  assign rf_issue_tag = capture ? rob_free_tag : '0;

  always_comb begin
    dis_rs_en  = (hold_dis && !is_ls(opc_q)) || (byp && !is_ls(in_opcode));
    dis_lsb_en = (hold_dis && is_ls(opc_q))  || (byp && is_ls(in_opcode));
    dis_opcode = '0;
    dis_rob_id = '0;
    dis_pc     = '0;
    dis_imm    = '0;
    dis_is_br  = 1'b0;
    dis_vi     = '0;
    dis_vj     = '0;
    dis_qi     = '0;
    dis_qj     = '0;
    dis_oi     = 1'b0;
    dis_oj     = 1'b0;
    if (byp) begin
      dis_opcode = in_opcode;
      dis_rob_id = rob_free_tag;
      dis_pc     = in_pc;
      dis_imm    = in_imm;
      dis_is_br  = in_is_br;
      dis_vi     = cvi;
      dis_vj     = cvj;
      dis_qi     = cqi;
      dis_qj     = cqj;
      dis_oi     = coi;
      dis_oj     = coj;
    end else if (state_q == ST_HOLD) begin
      dis_opcode = opc_q;
      dis_rob_id = rob_q;
      dis_pc     = pc_q;
      dis_imm    = imm_q;
      dis_is_br  = br_q;
      dis_vi     = hvi;
      dis_vj     = hvj;
      dis_qi     = hqi;
      dis_qj     = hqj;
      dis_oi     = hoi;
      dis_oj     = hoj;
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    br_d    = br_q;
    rob_d   = rob_q;
    vi_d    = vi_q;
    vj_d    = vj_q;
    qi_d    = qi_q;
    qj_d    = qj_q;
    oi_d    = oi_q;
    oj_d    = oj_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (rdy) begin
      if (state_q == ST_HOLD) begin
        vi_d = hvi;
        qi_d = hqi;
        oi_d = hoi;
        vj_d = hvj;
        qj_d = hqj;
        oj_d = hoj;
      end
      if (capture && !byp) begin
        state_d = ST_HOLD;
        opc_d   = in_opcode;
        pc_d    = in_pc;
        imm_d   = in_imm;
        br_d    = in_is_br;
        rob_d   = rob_free_tag;
        vi_d    = cvi;
        qi_d    = cqi;
        oi_d    = coi;
        vj_d    = cvj;
        qj_d    = cqj;
        oj_d    = coj;
      end else if (hold_dis) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      opc_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      br_q    <= 1'b0;
      rob_q   <= '0;
      vi_q    <= '0;
      vj_q    <= '0;
      qi_q    <= '0;
      qj_q    <= '0;
      oi_q    <= 1'b0;
      oj_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      br_q    <= br_d;
      rob_q   <= rob_d;
      vi_q    <= vi_d;
      vj_q    <= vj_d;
      qi_q    <= qi_d;
      qj_q    <= qj_d;
      oi_q    <= oi_d;
      oj_q    <= oj_d;
    end
  end

endmodule
